seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
Parametrised multi-cycle adder/subtractor. Operands are latched on a start handshake and processed CHUNK bits per clock, LSB chunk first, through one shared CHUNK-bit ripple-carry slice. Carry is registered between chunks. It is the area-reduced successor to the fixed 8-bit ripple-carry adder/subtractor and sits in the datapath/ALU layer.

Parameters:
WIDTH, 32, operand and result width in bits; WIDTH % CHUNK must be 0.
CHUNK, 8, bits processed per cycle; CHUNK == WIDTH gives a single-cycle operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE or DONE
mode  input  1  0 = add, 1 = subtract; latched at start
a  input  WIDTH  operand A; latched at start
b  input  WIDTH  operand B; latched at start
cin  input  1  add: carry-in; subtract: borrow-in; latched at start
busy  output  1  high while chunks are being processed
done  output  1  one-cycle pulse when the result is valid
sum  output  WIDTH  result; held stable from done until the next accepted start
cout  output  1  raw carry out of the MSB
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, carry=0, busy=0, done=0, sum=0, cout=0, ovf=0. Reset mid-operation aborts the operation. No done is issued.
- NCHUNK = WIDTH/CHUNK. Add: sum = a + b + cin. Subtract: sum = a + ~b + ~cin, which equals a - b - cin. In subtract mode, cout=1 means no borrow.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1, latch a, b' (b, or ~b when subtracting), carry=cin^mode, count=0, then go to RUN. busy=1 from the next cycle.
  - RUN: each cycle, add chunk[count] of a and b' plus carry. Write the result into sum[count*CHUNK +: CHUNK] and register the carry-out. When count==NCHUNK-1, also set cout = carry-out and ovf = (a[MSB]==b'[MSB]) && (result MSB != a[MSB]), then go to DONE. Otherwise count++.
  - DONE: busy=0, done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back operations). Otherwise go to IDLE.
- Latency: start sampled at edge k; busy high over cycles k+1..k+NCHUNK; done high in cycle k+NCHUNK+1. Throughput is one result per NCHUNK+1 cycles.
- start while busy=1 is ignored; latched operands are unaffected.
- Changes on a, b, mode or cin after the start edge have no effect.
- sum, cout and ovf are undefined-but-stable during RUN. Consumers read them only when done=1 or afterwards while idle.

Optional Feature:
SEQ_ADDSUB_FLAGS_EN
- Defined: adds outputs zero (1) and neg (1), updated together with cout/ovf on the final chunk. zero=1 iff sum==0; neg=sum[WIDTH-1]. Both reset to 0.
- Not defined: these ports and their logic do not exist. All other behaviour is identical.

Decomposition:
- Shared package seq_addsub_pkg: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and MODE_ADD/MODE_SUB constants.
- One sub-module, rca_chunk: a purely combinational CHUNK-bit ripple-carry adder (a, b, cin -> sum, cout), instantiated once.
- The FSM, counter and registers live in seq_addsub.

Test Plan:
- WIDTH=8, CHUNK=2, add, a=0x8A, b=0x23, cin=1 -> busy for 4 cycles, done in cycle 5, sum=0xAE, cout=0, ovf=0.
- Same operands, subtract, cin=1 (borrow) -> sum=0x66, cout=1, ovf=1.
- Add a=0x9F, b=0xC2, cin=1 -> sum=0x62, cout=1, ovf=1. Then, with start held high during done, add a=0x42, b=0x42, cin=0 -> second op accepted back-to-back, sum=0x84, cout=0, ovf=1.
- start pulsed with a=0xFF during busy of op a=0x01+b=0x01 -> second start ignored; result sum=0x02, exactly one done.
- Assert rst at the 2nd RUN cycle -> busy, done, sum, cout and ovf are all 0 immediately, no done pulse follows, and the next start completes normally.
- With SEQ_ADDSUB_FLAGS_EN, WIDTH=32, CHUNK=8: subtract 0x42-0x42, cin=0 -> sum=0, cout=1, zero=1, neg=0. Also run CHUNK=WIDTH=8 with 0x8A+0x23+1 -> done 2 cycles after start, sum=0xAE.

Source files
------------

// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the sequential chunked adder/subtractor.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/seq_addsub_rca_chunk.sv
// Purely combinational W-bit ripple-carry slice shared by every chunk step.
module rca_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle add/subtract, CHUNK bits per clock LSB first through one rca_chunk.
// Build option SEQ_ADDSUB_FLAGS_EN adds zero/neg result flags.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef SEQ_ADDSUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t           state;
  logic [CW-1:0]    count;
  logic             carry;
  logic [WIDTH-1:0] ra, rb;

  logic [CHUNK-1:0] ca, cb, cs;
  logic             co;
  logic [WIDTH-1:0] sum_nxt;
  logic             last;

  // Select the active chunk of the latched operands and splice its result into sum.
  always_comb begin
    ca      = '0;
    cb      = '0;
    sum_nxt = sum;
    for (int i = 0; i < NCHUNK; i++) begin
      if (count == CW'(i)) begin
        ca = ra[i*CHUNK +: CHUNK];
        cb = rb[i*CHUNK +: CHUNK];
        sum_nxt[i*CHUNK +: CHUNK] = cs;
      end
    end
  end

  assign last = (count == CW'(NCHUNK - 1));

  rca_chunk #(.W(CHUNK)) u_rca (
    .a   (ca),
    .b   (cb),
    .cin (carry),
    .sum (cs),
    .cout(co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      carry <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
`ifdef SEQ_ADDSUB_FLAGS_EN
      zero  <= 1'b0;
      neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= (mode == MODE_SUB) ? ~b : b;
            // Subtract folds the inverted borrow into the carry-in.
            carry <= cin ^ mode;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum   <= sum_nxt;
          carry <= co;
          if (last) begin
            cout  <= co;
            ovf   <= (ra[WIDTH-1] == rb[WIDTH-1]) && (cs[CHUNK-1] != ra[WIDTH-1]);
`ifdef SEQ_ADDSUB_FLAGS_EN
            zero  <= (sum_nxt == '0);
            neg   <= sum_nxt[WIDTH-1];
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub: 8/2, 32/8 and single-cycle 8/8 instances.
module tb_seq_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 8-bit, 2-bit chunks
  logic st8 = 0, md8 = 0, ci8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic bz8, dn8, co8, ov8;
  logic [7:0] s8;
  // 32-bit, 8-bit chunks
  logic st32 = 0, md32 = 0, ci32 = 0;
  logic [31:0] a32 = 0, b32 = 0;
  logic bz32, dn32, co32, ov32;
  logic [31:0] s32;
  // 8-bit single chunk
  logic st1 = 0, md1 = 0, ci1 = 0;
  logic [7:0] a1 = 0, b1 = 0;
  logic bz1, dn1, co1, ov1;
  logic [7:0] s1;
`ifdef SEQ_ADDSUB_FLAGS_EN
  logic z8, n8, z32, n32, z1, n1;
`endif

  seq_addsub #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .mode(md8), .a(a8), .b(b8), .cin(ci8),
    .busy(bz8), .done(dn8), .sum(s8), .cout(co8), .ovf(ov8)
`ifdef SEQ_ADDSUB_FLAGS_EN
    , .zero(z8), .neg(n8)
`endif
  );

  seq_addsub #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .start(st32), .mode(md32), .a(a32), .b(b32), .cin(ci32),
    .busy(bz32), .done(dn32), .sum(s32), .cout(co32), .ovf(ov32)
`ifdef SEQ_ADDSUB_FLAGS_EN
    , .zero(z32), .neg(n32)
`endif
  );

  seq_addsub #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .mode(md1), .a(a1), .b(b1), .cin(ci1),
    .busy(bz1), .done(dn1), .sum(s1), .cout(co1), .ovf(ov1)
`ifdef SEQ_ADDSUB_FLAGS_EN
    , .zero(z1), .neg(n1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic md,
                       input logic [31:0] av, input logic [31:0] bv, input logic ci);
    case (sel)
      0: begin st8 = st; md8 = md; a8 = av[7:0]; b8 = bv[7:0]; ci8 = ci; end
      1: begin st32 = st; md32 = md; a32 = av; b32 = bv; ci32 = ci; end
      default: begin st1 = st; md1 = md; a1 = av[7:0]; b1 = bv[7:0]; ci1 = ci; end
    endcase
  endtask

  task automatic peek(input int sel, output logic bz, output logic dn, output logic [31:0] s,
                      output logic co, output logic ov, output logic z, output logic ng);
    z = 0; ng = 0;
    case (sel)
      0: begin bz = bz8; dn = dn8; s = {24'd0, s8}; co = co8; ov = ov8; end
      1: begin bz = bz32; dn = dn32; s = s32; co = co32; ov = ov32; end
      default: begin bz = bz1; dn = dn1; s = {24'd0, s1}; co = co1; ov = ov1; end
    endcase
`ifdef SEQ_ADDSUB_FLAGS_EN
    case (sel)
      0: begin z = z8; ng = n8; end
      1: begin z = z32; ng = n32; end
      default: begin z = z1; ng = n1; end
    endcase
`endif
  endtask

  // One pulsed operation; operands are scrambled right after the start edge.
  task automatic run_op(input int sel, input logic md, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, output logic [31:0] s, output logic co, output logic ov,
                        output logic z, output logic ng, output int bc, output int dc, output int da);
    logic bz, dn, pco, pov, pz, pn;
    logic [31:0] ps;
    bc = 0; dc = 0; da = 0; s = 0; co = 0; ov = 0; z = 0; ng = 0;
    @(negedge clk);
    drive(sel, 1'b1, md, av, bv, ci);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      peek(sel, bz, dn, ps, pco, pov, pz, pn);
      if (c == 1) drive(sel, 1'b0, ~md, ~av, ~bv, ~ci);
      if (bz) bc++;
      if (dn) begin
        dc++;
        if (da == 0) begin da = c; s = ps; co = pco; ov = pov; z = pz; ng = pn; end
      end
    end
  endtask

  typedef struct {
    string      name;
    logic       md;
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] s;
    logic co, ov, z, ng, bz, dn, pco, pov, pz, pn;
    logic [31:0] ps;
    int bc, dc, da, d1, d2, ndone;

    vecs[0] = '{"add_8a_23",  1'b0, 8'h8A, 8'h23, 1'b1, 8'hAE, 1'b0, 1'b0};
    vecs[1] = '{"sub_8a_23",  1'b1, 8'h8A, 8'h23, 1'b1, 8'h66, 1'b1, 1'b1};
    vecs[2] = '{"add_9f_c2",  1'b0, 8'h9F, 8'hC2, 1'b1, 8'h62, 1'b1, 1'b1};
    vecs[3] = '{"add_ff_01",  1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{"sub_00_01",  1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{"add_7f_01",  1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{"sub_80_01",  1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{"add_55_aa",  1'b0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bz8}, 0);
    chk("rst_done", {31'd0, dn8}, 0);
    chk("rst_sum",  {24'd0, s8}, 0);
    chk("rst_cout", {31'd0, co8}, 0);
    chk("rst_ovf",  {31'd0, ov8}, 0);
    chk("rst_sum32", s32, 0);
    rst = 1'b0;

    // Table-driven vectors on the 4-chunk instance
    foreach (vecs[i]) begin
      run_op(0, vecs[i].md, {24'd0, vecs[i].a}, {24'd0, vecs[i].b}, vecs[i].ci,
             s, co, ov, z, ng, bc, dc, da);
      chk({vecs[i].name, "_busycyc"}, bc, 4);
      chk({vecs[i].name, "_doneat"}, da, 5);
      chk({vecs[i].name, "_ndone"}, dc, 1);
      chk({vecs[i].name, "_sum"}, s, {24'd0, vecs[i].s});
      chk({vecs[i].name, "_cout"}, {31'd0, co}, {31'd0, vecs[i].co});
      chk({vecs[i].name, "_ovf"}, {31'd0, ov}, {31'd0, vecs[i].ov});
    end

    // Back-to-back: start held through done, second operands presented at done
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h9F, 32'hC2, 1'b1);
    d1 = 0; d2 = 0; ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      peek(0, bz, dn, ps, pco, pov, pz, pn);
      if (d1 != 0 && c == d1 + 1) begin
        chk("b2b_accept_busy", {31'd0, bz}, 1);
        st8 = 1'b0;
      end
      if (dn) begin
        ndone++;
        if (d1 == 0) begin
          d1 = c;
          chk("b2b_sum1", ps, 32'h62);
          chk("b2b_cout1", {31'd0, pco}, 1);
          chk("b2b_ovf1", {31'd0, pov}, 1);
          a8 = 8'h42; b8 = 8'h42; ci8 = 1'b0;
        end else if (d2 == 0) begin
          d2 = c;
          chk("b2b_sum2", ps, 32'h84);
          chk("b2b_cout2", {31'd0, pco}, 0);
          chk("b2b_ovf2", {31'd0, pov}, 1);
        end
      end
    end
    chk("b2b_done1_at", d1, 5);
    chk("b2b_gap", d2 - d1, 5);
    chk("b2b_ndone", ndone, 2);

    // Start during busy is ignored
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h01, 32'h01, 1'b0);
    ndone = 0; s = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      peek(0, bz, dn, ps, pco, pov, pz, pn);
      if (c == 1) st8 = 1'b0;
      if (c == 2) begin st8 = 1'b1; a8 = 8'hFF; end
      if (c == 3) st8 = 1'b0;
      if (dn) begin ndone++; s = ps; end
    end
    chk("ign_sum", s, 32'h02);
    chk("ign_ndone", ndone, 1);

    // Reset during the second RUN cycle
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h8A, 32'h23, 1'b1);
    @(negedge clk);
    st8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bz8}, 0);
    chk("abort_done", {31'd0, dn8}, 0);
    chk("abort_sum",  {24'd0, s8}, 0);
    chk("abort_cout", {31'd0, co8}, 0);
    chk("abort_ovf",  {31'd0, ov8}, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dn8 || bz8) ndone++;
    end
    chk("abort_quiet", ndone, 0);
    run_op(0, 1'b0, 32'h8A, 32'h23, 1'b1, s, co, ov, z, ng, bc, dc, da);
    chk("after_abort_sum", s, 32'hAE);
    chk("after_abort_doneat", da, 5);
    chk("after_abort_ndone", dc, 1);

    // 32-bit instance
    run_op(1, 1'b0, 32'h12345678, 32'h0FEDCBA9, 1'b0, s, co, ov, z, ng, bc, dc, da);
    chk("w32_add_sum", s, 32'h22222221);
    chk("w32_add_busycyc", bc, 4);
    chk("w32_add_cout", {31'd0, co}, 0);
    run_op(1, 1'b1, 32'h42, 32'h42, 1'b0, s, co, ov, z, ng, bc, dc, da);
    chk("w32_sub_sum", s, 0);
    chk("w32_sub_cout", {31'd0, co}, 1);
    chk("w32_sub_ovf", {31'd0, ov}, 0);
`ifdef SEQ_ADDSUB_FLAGS_EN
    chk("w32_sub_zero", {31'd0, z}, 1);
    chk("w32_sub_neg", {31'd0, ng}, 0);
    run_op(1, 1'b1, 32'h0, 32'h1, 1'b0, s, co, ov, z, ng, bc, dc, da);
    chk("w32_neg_sum", s, 32'hFFFFFFFF);
    chk("w32_neg_zero", {31'd0, z}, 0);
    chk("w32_neg_neg", {31'd0, ng}, 1);
`endif

    // Single-chunk instance
    run_op(2, 1'b0, 32'h8A, 32'h23, 1'b1, s, co, ov, z, ng, bc, dc, da);
    chk("w8c8_sum", s, 32'hAE);
    chk("w8c8_busycyc", bc, 1);
    chk("w8c8_doneat", da, 2);
    chk("w8c8_ndone", dc, 1);
    run_op(2, 1'b1, 32'h8A, 32'h23, 1'b1, s, co, ov, z, ng, bc, dc, da);
    chk("w8c8_sub_sum", s, 32'h66);
    chk("w8c8_sub_ovf", {31'd0, ov}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
